// File: rtl/lsu_mem_port_if.sv
// Bundles the request/response handshake and the data-memory port of lsu_mem_port.
// slave = the load/store unit itself; master = the requester plus memory environment.
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_write_data, mem_write_en, mem_read_en
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_write_data, mem_write_en, mem_read_en
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store unit in front of a combinational-read, posedge-write data memory.
// Define LSU_SUBWORD_EN to enable byte/halfword accesses (sub-word stores use read-modify-write).
module lsu_mem_port (
  input logic           clk,
  input logic           rst_n,
  lsu_mem_port_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [31:0] store_word;

  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] off);
`ifdef LSU_SUBWORD_EN
    case (size)
      SZ_BYTE: req_illegal = 1'b0;
      SZ_HALF: req_illegal = off[0];
      SZ_WORD: req_illegal = (off != 2'b00);
      default: req_illegal = 1'b1;
    endcase
`else
    req_illegal = (size != SZ_WORD) || (off != 2'b00);
`endif
  endfunction

  // Little-endian lane extraction followed by sign/zero extension.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = '0;
    case (size)
      SZ_BYTE: begin
        sh = word >> {off, 3'b000};
        load_extend = {{24{~uns & sh[7]}}, sh[7:0]};
      end
      SZ_HALF: begin
        sh = word >> {off[1], 4'b0000};
        load_extend = {{16{~uns & sh[15]}}, sh[15:0]};
      end
      default: load_extend = word;
    endcase
  endfunction

`ifdef LSU_SUBWORD_EN
  function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] data,
                                              input logic [1:0] off, input logic [1:0] size);
    logic [31:0] mask;
    logic [4:0]  shamt;
    if (size == SZ_BYTE) begin
      shamt = {off, 3'b000};
      mask  = 32'h0000_00FF << shamt;
    end else begin
      shamt = {off[1], 4'b0000};
      mask  = 32'h0000_FFFF << shamt;
    end
    store_merge = (old_word & ~mask) | ((data << shamt) & mask);
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    write_d = write_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          write_d = bus.req_write;
          rdata_d = '0;
          err_d   = req_illegal(bus.req_size, bus.req_addr[1:0]);
          if (err_d) begin
            state_d = S_RESP;
          end else if (!bus.req_write) begin
            state_d = S_RD;
`ifdef LSU_SUBWORD_EN
          end else if (bus.req_size != SZ_WORD) begin
            state_d = S_RD;
`endif
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_RD: begin
        rdata_d = bus.mem_read_data;
        state_d = write_q ? S_WR : S_RESP;
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
`ifdef LSU_SUBWORD_EN
    store_word = (size_q == SZ_WORD) ? wdata_q
                                     : store_merge(rdata_q, wdata_q, addr_q[1:0], size_q);
`else
    store_word = wdata_q;
`endif
  end

  // Every output is gated by rst_n so a store caught in WR during reset never strobes memory.
  always_comb begin
    bus.req_ready      = rst_n && (state_q == S_IDLE);
    bus.resp_valid     = rst_n && (state_q == S_RESP);
    bus.resp_err       = bus.resp_valid && err_q;
    bus.resp_rdata     = (bus.resp_valid && !err_q && !write_q)
                         ? load_extend(rdata_q, addr_q[1:0], size_q, uns_q) : '0;
    bus.mem_read_en    = rst_n && (state_q == S_RD);
    bus.mem_write_en   = rst_n && (state_q == S_WR);
    bus.mem_address    = (rst_n && (state_q != S_IDLE)) ? {addr_q[31:2], 2'b00} : '0;
    bus.mem_write_data = bus.mem_write_en ? store_word : '0;
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: a byte-addressed reference memory predicts each response,
// a negedge monitor checks responses, latency and memory strobe counts.
module tb_lsu_mem_port;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_port_if bus();
  lsu_mem_port dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Environment memory: 16 words, combinational read, posedge write.
  logic [31:0] mem [16] = '{default: 32'h0};
  assign bus.mem_read_data = mem[bus.mem_address[5:2]];
  always @(posedge clk) if (bus.mem_write_en) mem[bus.mem_address[5:2]] <= bus.mem_write_data;

  // Reference model memory kept as individual bytes.
  logic [7:0] ref_b [64] = '{default: 8'h0};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          nrd;
    int          nwr;
    int          rd0;
    int          wr0;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int req_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[idx*4+3], ref_b[idx*4+2], ref_b[idx*4+1], ref_b[idx*4]};
  endfunction

  task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int  n;
    int  ai;
    logic [31:0] v;
    ai = int'(a[5:0]);
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.rdata = 32'h0; e.nrd = 0; e.nwr = 0; e.lat = 1;
`ifdef LSU_SUBWORD_EN
    e.err = (sz == 2'd3) || (ai % n != 0);
`else
    e.err = (sz != 2'd2) || (ai % 4 != 0);
`endif
    if (e.err) return;
    if (!wr) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v + (32'(ref_b[ai+i]) << (8*i));
      if (!uns && n < 4 && v[8*n-1]) v = v + (32'hFFFF_FFFF << (8*n));
      e.rdata = v; e.nrd = 1; e.lat = 2;
    end else begin
      for (int i = 0; i < n; i++) ref_b[ai+i] = 8'((wd >> (8*i)) & 32'hFF);
      e.nwr = 1;
      e.nrd = (n < 4) ? 1 : 0;
      e.lat = (n < 4) ? 3 : 2;
    end
  endtask

  // Drive one request, wait (bounded) for acceptance, then push its expected response.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit track);
    bit   acc;
    exp_t e;
    acc = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready stayed 0 for addr 0x%08h", a);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (track) begin
      model(wr, sz, uns, a, wd, e);
      e.acc = cyc; e.rd0 = rd_cnt; e.wr0 = wr_cnt; e.id = req_id;
      req_id++;
      exp_q.push_back(e);
    end
  endtask

  initial forever begin @(posedge clk); cyc++; end
  initial forever begin
    @(negedge clk);
    if (bus.mem_read_en) rd_cnt++;
    if (bus.mem_write_en) wr_cnt++;
  end

  // Monitor: pops one expectation per resp_valid pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding, rdata 0x%08h", bus.resp_rdata);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("req%0d_rdata", e.id), bus.resp_rdata, e.rdata);
          check($sformatf("req%0d_err", e.id), 32'(bus.resp_err), 32'(e.err));
          check($sformatf("req%0d_latency", e.id), 32'(cyc - e.acc + 1), 32'(e.lat));
          check($sformatf("req%0d_reads", e.id), 32'(rd_cnt - e.rd0), 32'(e.nrd));
          check($sformatf("req%0d_writes", e.id), 32'(wr_cnt - e.wr0), 32'(e.nwr));
        end
      end else if (rst_n) begin
        check("idle_resp_outputs", {bus.resp_rdata[31:1], bus.resp_rdata[0] | bus.resp_err}, 32'h0);
      end
    end
  end

  initial begin
    logic        wr, uns;
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 32'h0);
    check("reset_mem_write_en", 32'(bus.mem_write_en), 32'h0);
    check("reset_mem_address", bus.mem_address, 32'h0);
    rst_n = 1'b1;
    #1 check("release_req_ready", 32'(bus.req_ready), 32'h1);

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);  // sw
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);         // lw
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1);         // lb
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1);         // lbu
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1);         // lh
    issue(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 1'b1);         // lhu
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h55, 1'b1);        // sb
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);         // lw of merged word
    issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 1'b1);         // misaligned lw
    issue(1'b1, 2'd1, 1'b0, 32'h11, 32'h0, 1'b1);         // misaligned sh
    issue(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 1'b1);         // illegal size
    repeat (4) @(negedge clk);

    // Reset while a store sits in its write cycle: nothing may reach memory.
`ifdef LSU_SUBWORD_EN
    issue(1'b1, 2'd1, 1'b0, 32'h10, 32'h1234, 1'b0);
`else
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234, 1'b0);
`endif
    r = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_write_en) begin r = 1; break; end
    end
    check("wr_cycle_reached", 32'(r), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wr_write_en", 32'(bus.mem_write_en), 32'h0);
    check("rst_mid_wr_req_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("after_release_req_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    check("after_release_req_ready_cycle", 32'(bus.req_ready), 32'h1);
    check("rst_mid_wr_word_kept", mem[4], ref_word(4));

    for (int k = 0; k < 300; k++) begin
      wr  = 1'($urandom % 2);
      uns = 1'($urandom % 2);
      r   = int'($urandom % 8);
      sz  = (r < 7) ? 2'(r % 3) : 2'd3;
      a   = 32'($urandom_range(0, 63));
      if ($urandom % 4 != 0) a = (sz == 2'd1) ? (a & ~32'h1) : (sz == 2'd2) ? (a & ~32'h3) : a;
      issue(wr, sz, uns, a, $urandom, 1'b1);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("responses_drained", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) check($sformatf("mem_word%0d", i), mem[i], ref_word(i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit that issues word-granular accesses to the single-cycle data memory on behalf of the CPU datapath. It accepts one load/store request at a time over a valid/ready handshake, performs alignment checks and byte/halfword lane extraction or read-modify-write, drives the memory's address/write_data/mem_write_en/mem_read_en port, and returns one response per request. It sits between the execute stage and `data_memory`, which provides a combinational read and a posedge write.

## Interface
- No parameters.
- `clk` in 1: system clock; all state updates on posedge.
- `rst_n` in 1: synchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = halfword, 2 = word; 3 is illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified for sub-word stores.
- `resp_valid` out 1: one-cycle pulse, response available.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal-size request; valid with `resp_valid`.
- `mem_address` out 32: word address `{addr[31:2],2'b00}`.
- `mem_write_data` out 32: word to write.
- `mem_write_en` out 1: memory write strobe.
- `mem_read_en` out 1: memory read enable.
- `mem_read_data` in 32: combinational read data from memory.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE: `req_ready`=1. Accept on `req_valid && req_ready`; register addr, size, unsigned, write, wdata.
- Error check on accept: size 3, half with addr[0]=1, or word with addr[1:0]≠0 → RESP with `resp_err`=1; no memory access.
- Load: IDLE→RD→RESP. In RD: `mem_read_en`=1; capture `mem_read_data` at the end of RD.
- Word store: IDLE→WR→RESP. In WR: `mem_write_en`=1 and `mem_write_data`=wdata.
- Sub-word store: IDLE→RD→WR→RESP. RD captures the old word; WR writes the merged word, with only the addressed lane(s) replaced.
- Lane mapping is little-endian: the byte at addr[1:0]=k occupies bits [8k+7:8k]; the halfword at addr[1]=h occupies bits [16h+15:16h].
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. There is no response backpressure; the consumer must take it.
- `mem_read_en` is high only in RD. `mem_write_en` is high only in WR, qualified by `rst_n`. `mem_address` is held from the registered addr in all non-IDLE states and is 0 in IDLE.
- Outputs outside of RESP: `resp_rdata`=0, `resp_err`=0.

## Timing
- Acceptance edge = T. Error: `resp_valid` in cycle T+1.
- Load and word store: `resp_valid` in cycle T+2.
- Sub-word store: `resp_valid` in cycle T+3.
- Throughput: at most one request per 2–4 cycles. `req_ready` drops in the cycle after acceptance.
- Reset (`rst_n` low at a posedge): state→IDLE and all registers cleared.
  - While `rst_n` is low, all outputs are 0, including `req_ready` and `mem_write_en`. A store caught in WR during reset is not written.
  - In the first cycle after release, `req_ready`=1.
- A request presented in RESP is not accepted; it is accepted in the following IDLE cycle.

## Configuration
- `LSU_SUBWORD_EN` defined: byte/halfword loads and stores are supported as described above.
- `LSU_SUBWORD_EN` undefined: only size 2 is legal. Sizes 0, 1 and 3 return `resp_err`=1 in T+1 with no memory access. The RD-before-WR merge path is absent, and stores always go IDLE→WR→RESP.

## Test plan
- sw addr 0x10 data 0xDEADBEEF, then lw 0x10 → `resp_rdata`=0xDEADBEEF, `resp_err`=0, each `resp_valid` at T+2, `mem_write_en` high exactly one cycle.
- After the first scenario: lb 0x13 → 0xFFFFFFDE; lbu 0x13 → 0x000000DE; lh 0x12 → 0xFFFFDEAD; lhu 0x10 → 0x0000BEEF.
- sb addr 0x11 data 0x00000055 on word 0xDEADBEEF → one read cycle, then one write cycle with `mem_write_data`=0xDEAD55EF; `resp_valid` at T+3.
- lw 0x12, sh 0x11, size=3 at 0x20 → `resp_err`=1 at T+1; `mem_read_en` and `mem_write_en` never asserted.
- `rst_n` low during the WR cycle of sh 0x10 data 0x1234 → no memory write, word unchanged, `resp_valid` never asserted; `req_ready`=1 in the first cycle after release.
- `LSU_SUBWORD_EN` undefined: lb 0x10 → `resp_err`=1 at T+1; sw and lw still behave as in the first scenario.
